regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the 32×32 integer register file. It shares the file's single write port (`we3`/`A3`/`WD3`) among `NUM_REQ` write-back requesters, such as the ALU result path and the load unit. Arbitration is round-robin with a valid/ready handshake, and the winning write is registered before it drives the register file. The block drops writes to `$0` and flags read-after-write hazards against the register file's two read ports.

---
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register file's single write port.
// Registers the winning write, drops $0 writes and flags read-after-write hazards.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        wb_stall,
    output logic                        we3,
    output logic [ADDR_W-1:0]           A3,
    output logic [DATA_W-1:0]           WD3,
    output logic [IW-1:0]               grant_id,
    input  logic [ADDR_W-1:0]           A1,
    input  logic [ADDR_W-1:0]           A2,
    output logic                        hazard1,
    output logic                        hazard2,
    output logic [CNT_W-1:0]            wr_count
);

    logic [IW-1:0]     last;
    logic [IW-1:0]     win;
    logic              found;
    logic              transfer;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] data_w;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && rst_n && !wb_stall)
            req_ready = NUM_REQ'(1) << win;
    end

    assign transfer = |req_ready;
    assign addr_w   = req_addr[win*ADDR_W +: ADDR_W];
    assign data_w   = req_data[win*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last     <= IW'(NUM_REQ - 1);
            we3      <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
            grant_id <= '0;
            wr_count <= '0;
        end else begin
            // $0 writes still consume a grant but never reach the write port.
            we3 <= transfer && (addr_w != '0);
            if (transfer) begin
                last     <= win;
                A3       <= addr_w;
                WD3      <= data_w;
                grant_id <= win;
            end
            if (transfer && (addr_w != '0))
                wr_count <= wr_count + CNT_W'(1);
        end
    end

    assign hazard1 = we3 && (A3 == A1) && (A3 != '0);
    assign hazard2 = we3 && (A3 == A2) && (A3 != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a
// rule-level model of the round-robin write-back behaviour.
module tb_regfile_wb_arbiter;
    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              wb_stall;
    logic              we3;
    logic [AW-1:0]     A3;
    logic [DW-1:0]     WD3;
    logic [0:0]        grant_id;
    logic [AW-1:0]     A1, A2;
    logic              hazard1, hazard2;
    logic [CW-1:0]     wr_count;

    regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
        .we3(we3), .A3(A3), .WD3(WD3), .grant_id(grant_id), .A1(A1), .A2(A2),
        .hazard1(hazard1), .hazard2(hazard2), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // reference state: staged write, pointer and committed count
    int          m_last = N - 1;
    bit          m_we   = 1'b0;
    logic [AW-1:0] m_a3 = '0;
    logic [DW-1:0] m_wd = '0;
    int          m_gid  = 0;
    int          m_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // One clock: check combinational outputs, advance model at the edge, check registers.
    task automatic cycle();
        int w;
        bit found;
        logic [N-1:0] er;
        logic [AW-1:0] a;
        #1;
        found = 0;
        w = 0;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (!found && req_valid[i]) begin
                found = 1;
                w = i;
            end
        end
        er = '0;
        if (found && rst_n && !wb_stall) er[w] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("hazard1", hazard1, m_we && (m_a3 == A1) && (m_a3 != 0));
        chk("hazard2", hazard2, m_we && (m_a3 == A2) && (m_a3 != 0));
        a = req_addr[w*AW +: AW];
        @(posedge clk);
        if (!rst_n) begin
            m_we = 0; m_a3 = '0; m_wd = '0; m_gid = 0; m_cnt = 0; m_last = N - 1;
        end else begin
            m_we = (er != 0) && (a != 0);
            if (er != 0) begin
                m_a3   = a;
                m_wd   = req_data[w*DW +: DW];
                m_gid  = w;
                m_last = w;
                if (a != 0) m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end
        #1;
        chk("we3", we3, m_we);
        chk("A3", A3, m_a3);
        chk("WD3", WD3, m_wd);
        chk("grant_id", grant_id, m_gid);
        chk("wr_count", wr_count, m_cnt);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; wb_stall = 1'b0; A1 = '0; A2 = '0;
        req_valid = '0; req_addr = '0; req_data = '0;
        set_req(0, 1, 5'd3, 32'hAAAA_0000);
        set_req(1, 1, 5'd7, 32'h5555_0000);
        @(posedge clk);
        @(negedge clk);

        // reset held with everyone valid
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("rst_ready", req_ready, 2'b00);
            chk("rst_cnt", wr_count, 0);
        end
        rst_n = 1'b1;
        #1 chk("first_grant", req_ready, 2'b01);

        // fairness: alternating grants 0,1,0,1
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("fair_gid", grant_id, c % 2);
            chk("fair_a3", A3, (c % 2) ? 7 : 3);
            chk("fair_we3", we3, 1);
        end
        chk("fair_cnt", wr_count, 4);

        // $0 write: accepted, not committed, pointer advances
        set_req(0, 1, 5'd0, 32'hDEAD_BEEF);
        set_req(1, 0, 5'd7, 32'h5555_0000);
        #1 chk("zero_ready", req_ready, 2'b01);
        cycle();
        chk("zero_we3", we3, 0);
        chk("zero_cnt", wr_count, 4);
        set_req(0, 1, 5'd3, 32'hAAAA_0000);
        set_req(1, 1, 5'd7, 32'h5555_0000);
        #1 chk("zero_ptr", req_ready, 2'b10);
        cycle();

        // stall freezes arbitration
        wb_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("stall_ready", req_ready, 2'b00);
            chk("stall_we3", we3, 0);
        end
        wb_stall = 1'b0;
        #1 chk("stall_resume", req_ready, 2'b01);
        cycle();

        // hazard on port 1 only
        set_req(0, 1, 5'd5, 32'h1234_5678);
        set_req(1, 0, 5'd0, 32'h0);
        A1 = 5'd5; A2 = 5'd6;
        cycle();
        set_req(0, 0, 5'd5, 32'h1234_5678);
        #1;
        chk("haz1_hit", hazard1, 1);
        chk("haz2_miss", hazard2, 0);
        cycle();
        chk("haz1_idle", hazard1, 0);
        chk("haz2_idle", hazard2, 0);

        // reset mid-operation discards the staged write
        set_req(0, 1, 5'd9, 32'hCAFE_0009);
        cycle();
        chk("pre_rst_we3", we3, 1);
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_we3", we3, 0);
        chk("mid_rst_cnt", wr_count, 0);
        rst_n = 1'b1;

        // counter wrap: 17 writes on a 4-bit counter
        set_req(0, 1, 5'd1, 32'h0000_0001);
        set_req(1, 0, 5'd0, 32'h0);
        for (int c = 0; c < 17; c++) cycle();
        chk("cnt_wrap", wr_count, 1);

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 3) != 0,
                        ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom),
                        $urandom);
            wb_stall = ($urandom_range(0, 7) == 0);
            rst_n    = ($urandom_range(0, 40) != 0);
            A1       = AW'($urandom);
            A2       = ($urandom_range(0, 1) == 0) ? m_a3 : AW'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
